instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front end of the single-cycle-class CPU datapath. Fetches 32-bit instruction words from instruction memory through a busywait handshake and splits each word into OPCODE and operand fields for the control unit and register file. It owns the PC and computes the next PC from the control unit's BRANCH code and the ALU ZERO flag. It is the producer of OPCODE and the consumer of BRANCH: the other end of the control unit's interface.

## Interface
- IMEM_AW, default 8: instruction-memory word-address width.
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- IMEM_READ  output  1  instruction read request.
- IMEM_ADDRESS  output  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
- IMEM_BUSYWAIT  input  1  memory not ready; IMEM_INSTR is invalid while high.
- IMEM_INSTR  input  32  instruction word.
- PC  output  32  address of the current instruction.
- OPCODE  output  8  IR[31:24].
- RD  output  3  IR[18:16].
- RT  output  3  IR[10:8].
- RS  output  3  IR[2:0].
- IMMEDIATE  output  8  IR[7:0].
- OFFSET  output  8  IR[23:16], signed word offset.
- INSTR_VALID  output  1  the fields hold the instruction being executed.
- BRANCH  input  2  branch code from the control unit: 00 none, 01 J, 10 BEQ, 11 BNE.
- ZERO  input  1  ALU zero flag.
- STALL  input  1  downstream stall (data-memory busywait). Holds the current instruction.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- Reset state and values (applied immediately on RESET_N low):
  - state IDLE, PC=0, IR=0, IMEM_READ=0, INSTR_VALID=0.
  - All field outputs are 0 because they are slices of IR.
- IDLE → FETCH unconditionally on the first edge after reset release.
- FETCH:
  - IMEM_READ=1; IMEM_ADDRESS driven from PC.
  - If IMEM_BUSYWAIT=1 at the edge: stay in FETCH. Request and address stay stable.
  - If IMEM_BUSYWAIT=0 at the edge: IR←IMEM_INSTR, go to EXEC.
- EXEC:
  - IMEM_READ=0, INSTR_VALID=1. Field outputs are stable for the whole state.
  - If STALL=1 at the edge: stay in EXEC. PC and IR hold; INSTR_VALID stays 1.
  - If STALL=0 at the edge: PC←next_pc, go to FETCH.
- next_pc:
  - Sequential value: PC+4.
  - Taken target: PC+4+(sext32(OFFSET)<<2).
  - The branch is taken when BRANCH=01, or BRANCH=10 and ZERO=1, or BRANCH=11 and ZERO=0. Otherwise next_pc is the sequential value.
- Arithmetic is modulo 2^32. Wrap-around is silent. PC[1:0] is always 00.
- BRANCH and ZERO are sampled only at the EXEC exit edge and ignored in every other state.
- IMEM_INSTR is sampled only in FETCH with IMEM_BUSYWAIT=0.
- OFFSET=0xFF on a taken branch targets the branch itself, giving a legal self-loop.
- Unknown opcodes are passed through unchanged. This block does not decode or validate opcodes.

## Timing
- Minimum 2 cycles per instruction with a zero-wait memory: FETCH then EXEC.
- Each busywait cycle adds 1 cycle in FETCH. Each STALL cycle adds 1 cycle in EXEC.
- The control unit decodes OPCODE with a #1 delay. BRANCH and ALU ZERO therefore must settle within the EXEC cycle; the clock period must exceed the decode delay plus the ALU delay.
- INSTR_VALID rises on the FETCH→EXEC edge and falls on the EXEC→FETCH edge.
- RESET_N asserted in any state, including mid-busywait, takes effect asynchronously with the reset values above. The pending memory read is abandoned.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (ADD 0x00 … ROR 0x0D);
  - BRANCH encodings BR_NONE, BR_J, BR_EQ, BR_NE;
  - ALUOP encodings;
  - instruction field bit positions;
  - the fetch state enum.
- One natural sub-module, pc_next_logic: combinational sequential/target adders plus the taken decision.
- The FSM and the PC/IR registers live in the top module.

## Test plan
- **Reset and sequential fetch.** Stimulus: release RESET_N; zero-wait memory returning ADD words. Required: PC = 0, 4, 8, 0xC; INSTR_VALID high every other cycle; IMEM_ADDRESS = 0, 1, 2, 3.
- **Busywait.** Stimulus: IMEM_BUSYWAIT high for 3 cycles at PC=0x04. Required: IMEM_READ held for 4 cycles with IMEM_ADDRESS=1 stable; IR captured on the first edge with busywait low; EXEC follows.
- **Jump.** Stimulus: J with OFFSET=0xFE at PC=0x10. Required: next PC=0x0C. Same test with OFFSET=0xFF: PC stays at 0x10.
- **Conditional branches.** Stimulus: BEQ with OFFSET=0x03 at PC=0x08. Required: ZERO=1 gives 0x18; ZERO=0 gives 0x0C. BNE with the same inputs gives the inverse results.
- **Downstream stall.** Stimulus: STALL high for 4 cycles during EXEC of OR at PC=0x20. Required: INSTR_VALID, OPCODE=0x03 and PC=0x20 all held; PC becomes 0x24 on the edge after STALL falls.
- **Reset and wrap-around.**
  - Stimulus: RESET_N pulsed low during a FETCH busywait. Required: immediate PC=0, IMEM_READ=0, INSTR_VALID=0, then fetch restarts at address 0.
  - Stimulus: sequential step from PC=0xFFFFFFFC. Required: PC=0x00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, branch/ALU encodings, instruction field
// positions and fetch state type for the CPU datapath.
package cpu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h04;
  localparam logic [7:0] OP_LOADI = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_SLL   = 8'h09;
  localparam logic [7:0] OP_SRL   = 8'h0A;
  localparam logic [7:0] OP_SRA   = 8'h0B;
  localparam logic [7:0] OP_ROL   = 8'h0C;
  localparam logic [7:0] OP_ROR   = 8'h0D;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_J    = 2'b01;
  localparam logic [1:0] BR_EQ   = 2'b10;
  localparam logic [1:0] BR_NE   = 2'b11;

  localparam logic [2:0] ALU_FWD   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b100;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int OFF_MSB = 23;
  localparam int OFF_LSB = 16;
  localparam int RD_MSB  = 18;
  localparam int RD_LSB  = 16;
  localparam int RT_MSB  = 10;
  localparam int RT_LSB  = 8;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  function automatic logic br_taken(
    input logic [1:0] br,
    input logic       zero
  );
    logic t;
    t = 1'b0;
    unique case (br)
      BR_J:    t = 1'b1;
      BR_EQ:   t = zero;
      BR_NE:   t = !zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: sequential and branch-target adders plus the
// taken decision that selects between them.
module pc_next_logic
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [7:0]  i_offset,
  input  logic [1:0]  i_branch,
  input  logic        i_zero,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_seq;
  logic [31:0] w_ext;
  logic [31:0] w_tgt;
  logic        w_taken;

  assign w_seq   = i_pc + 32'd4;
  // word offset: sign-extend then scale to bytes
  assign w_ext   = {{22{i_offset[7]}}, i_offset, 2'b00};
  assign w_tgt   = w_seq + w_ext;
  assign w_taken = br_taken(i_branch, i_zero);

  assign o_next_pc = w_taken ? w_tgt : w_seq;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns PC and IR, fetches through a busywait
// handshake and presents the IR fields to control and register file.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  output logic               IMEM_READ,
  output logic [IMEM_AW-1:0] IMEM_ADDRESS,
  input  logic               IMEM_BUSYWAIT,
  input  logic [31:0]        IMEM_INSTR,
  output logic [31:0]        PC,
  output logic [7:0]         OPCODE,
  output logic [2:0]         RD,
  output logic [2:0]         RT,
  output logic [2:0]         RS,
  output logic [7:0]         IMMEDIATE,
  output logic [7:0]         OFFSET,
  output logic               INSTR_VALID,
  input  logic [1:0]         BRANCH,
  input  logic               ZERO,
  input  logic               STALL
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [31:0]  w_next_pc;

  pc_next_logic u_pc_next (
    .i_pc      (r_pc),
    .i_offset  (r_ir[OFF_MSB:OFF_LSB]),
    .i_branch  (BRANCH),
    .i_zero    (ZERO),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_pc    <= 32'd0;
      r_ir    <= 32'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            r_ir    <= IMEM_INSTR;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!STALL) begin
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IMEM_READ    = (r_state == ST_FETCH);
  assign INSTR_VALID  = (r_state == ST_EXEC);
  assign IMEM_ADDRESS = r_pc[IMEM_AW+1:2];
  assign PC           = r_pc;

  assign OPCODE    = r_ir[OPC_MSB:OPC_LSB];
  assign OFFSET    = r_ir[OFF_MSB:OFF_LSB];
  assign RD        = r_ir[RD_MSB:RD_LSB];
  assign RT        = r_ir[RT_MSB:RT_LSB];
  assign RS        = r_ir[RS_MSB:RS_LSB];
  assign IMMEDIATE = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch unit,
// one task per scenario, memory modelled as a word array.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IMEM_READ;
  logic [7:0]  IMEM_ADDRESS;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_INSTR;
  logic [31:0] PC;
  logic [7:0]  OPCODE;
  logic [2:0]  RD;
  logic [2:0]  RT;
  logic [2:0]  RS;
  logic [7:0]  IMMEDIATE;
  logic [7:0]  OFFSET;
  logic        INSTR_VALID;
  logic [1:0]  BRANCH = 2'b00;
  logic        ZERO = 1'b0;
  logic        STALL = 1'b0;

  logic [31:0] mem [0:255];

  always #5 CLK = ~CLK;

  // garbage while busy so an early capture is visible
  assign IMEM_INSTR = IMEM_BUSYWAIT ? 32'hDEADBEEF : mem[IMEM_ADDRESS];

  instruction_fetch_unit #(.IMEM_AW(8)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_INSTR    (IMEM_INSTR),
    .PC            (PC),
    .OPCODE        (OPCODE),
    .RD            (RD),
    .RT            (RT),
    .RS            (RS),
    .IMMEDIATE     (IMMEDIATE),
    .OFFSET        (OFFSET),
    .INSTR_VALID   (INSTR_VALID),
    .BRANCH        (BRANCH),
    .ZERO          (ZERO),
    .STALL         (STALL)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
    logic [1:0]  br;
    logic        z;
    int          bw;
    int          st;
    logic [31:0] npc;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] pc;
    logic [7:0]  opc;
    logic [7:0]  off;
    logic [7:0]  imm;
    logic [2:0]  rd;
    logic [2:0]  rt;
    logic [2:0]  rs;
    logic        valid;
    logic        rd_exec;
    int          rd_cycles;
    logic        rd_ok;
    logic        hold_ok;
    logic [31:0] npc;
    logic        vld_after;
  } obs_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] mk(
    input logic [7:0] op,
    input logic [7:0] off,
    input logic [7:0] mid,
    input logic [7:0] imm
  );
    return {op, off, mid, imm};
  endfunction

  function automatic exp_t mkexp(
    input logic [31:0] pc,
    input logic [31:0] w,
    input logic [1:0]  br,
    input logic        z,
    input int          bw,
    input int          st,
    input logic [31:0] npc
  );
    exp_t e;
    e.pc = pc; e.w = w; e.br = br; e.z = z;
    e.bw = bw; e.st = st; e.npc = npc;
    return e;
  endfunction

  // Drives one instruction: entered and left on a negedge in FETCH.
  task automatic exec_one(
    input  int         bw,
    input  int         st,
    input  logic [1:0] br,
    input  logic       z,
    output obs_t       o
  );
    logic [7:0] a0;
    o.rd_ok = 1'b1;
    o.hold_ok = 1'b1;
    o.rd_cycles = 0;
    a0 = IMEM_ADDRESS;
    o.addr = a0;
    BRANCH = BR_J;
    ZERO = ~z;
    for (int i = 0; i < bw; i++) begin
      IMEM_BUSYWAIT = 1'b1;
      if (!(IMEM_READ === 1'b1 && IMEM_ADDRESS === a0)) o.rd_ok = 1'b0;
      o.rd_cycles++;
      @(negedge CLK);
    end
    IMEM_BUSYWAIT = 1'b0;
    if (!(IMEM_READ === 1'b1 && IMEM_ADDRESS === a0)) o.rd_ok = 1'b0;
    o.rd_cycles++;
    @(negedge CLK);
    o.pc = PC; o.opc = OPCODE; o.off = OFFSET; o.imm = IMMEDIATE;
    o.rd = RD; o.rt = RT; o.rs = RS;
    o.valid = INSTR_VALID;
    o.rd_exec = IMEM_READ;
    for (int i = 0; i < st; i++) begin
      STALL = 1'b1;
      BRANCH = BR_J;
      @(negedge CLK);
      if (!(INSTR_VALID === 1'b1 && PC === o.pc && OPCODE === o.opc))
        o.hold_ok = 1'b0;
    end
    STALL = 1'b0;
    BRANCH = br;
    ZERO = z;
    @(negedge CLK);
    o.npc = PC;
    o.vld_after = INSTR_VALID;
    BRANCH = BR_NONE;
    ZERO = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_chk++;
    if (PC !== 32'h0 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: pc=%h rd=%b vld=%b, required 0/0/0", PC, IMEM_READ, INSTR_VALID);
    end
    n_chk++;
    if ({OPCODE, OFFSET, RT, RS, IMMEDIATE} !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_fields: op=%h off=%h rt=%h rs=%h imm=%h, required 0", OPCODE, OFFSET, RT, RS, IMMEDIATE);
    end
    RESET_N = 1'b1;
    #1;
    n_chk++;
    if (IMEM_READ !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rd=%b, required 0", IMEM_READ);
    end
    @(negedge CLK);
    n_chk++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_first_fetch: rd=%b addr=%h, required 1/00", IMEM_READ, IMEM_ADDRESS);
    end
  endtask

  task automatic test_seq();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h00, mk(OP_ADD, 8'h12, 8'h03, 8'h45), BR_NONE, 1'b0, 0, 0, 32'h04));
    sb.push_back(mkexp(32'h04, mk(OP_ADD, 8'h35, 8'h06, 8'h67), BR_NONE, 1'b1, 0, 0, 32'h08));
    sb.push_back(mkexp(32'h08, mk(OP_ADD, 8'h07, 8'h05, 8'h01), BR_NONE, 1'b0, 0, 0, 32'h0C));
    sb.push_back(mkexp(32'h0C, mk(OP_ADD, 8'hA1, 8'h02, 8'hF3), BR_NONE, 1'b1, 0, 0, 32'h10));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.pc !== e.pc || o.addr !== e.pc[9:2]) begin
        n_fail++;
        $display("FAIL seq_pc: pc=%h addr=%h, required pc=%h addr=%h", o.pc, o.addr, e.pc, e.pc[9:2]);
      end
      n_chk++;
      if ({o.opc, o.off, o.rd, o.rt, o.rs, o.imm} !==
          {e.w[31:24], e.w[23:16], e.w[18:16], e.w[10:8], e.w[2:0], e.w[7:0]}) begin
        n_fail++;
        $display("FAIL seq_fields: op=%h off=%h rd=%h rt=%h rs=%h imm=%h, required word %h",
                 o.opc, o.off, o.rd, o.rt, o.rs, o.imm, e.w);
      end
      n_chk++;
      if (o.valid !== 1'b1 || o.rd_exec !== 1'b0 || o.vld_after !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_valid: vld=%b rd=%b vld_after=%b, required 1/0/0", o.valid, o.rd_exec, o.vld_after);
      end
      n_chk++;
      if (o.npc !== e.npc) begin
        n_fail++;
        $display("FAIL seq_next_pc: pc=%h, required %h", o.npc, e.npc);
      end
    end
  endtask

  task automatic test_jump();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h10, mk(OP_J, 8'hFF, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'h10));
    sb.push_back(mkexp(32'h10, mk(OP_J, 8'hFE, 8'h00, 8'h00), BR_J, 1'b1, 0, 0, 32'h0C));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.pc !== e.pc || o.opc !== e.w[31:24] || o.off !== e.w[23:16]) begin
        n_fail++;
        $display("FAIL jump_instr: pc=%h op=%h off=%h, required pc=%h op=%h off=%h",
                 o.pc, o.opc, o.off, e.pc, e.w[31:24], e.w[23:16]);
      end
      n_chk++;
      if (o.npc !== e.npc) begin
        n_fail++;
        $display("FAIL jump_target: pc=%h, required %h", o.npc, e.npc);
      end
    end
  endtask

  task automatic test_busywait();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h0C, mk(OP_J, 8'hFD, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'h04));
    sb.push_back(mkexp(32'h04, mk(OP_SUB, 8'h5C, 8'h01, 8'h2A), BR_NONE, 1'b0, 3, 0, 32'h08));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.rd_cycles != e.bw + 1 || o.rd_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_read: cycles=%0d stable=%b, required %0d/1", o.rd_cycles, o.rd_ok, e.bw + 1);
      end
      n_chk++;
      if (o.pc !== e.pc || o.addr !== e.pc[9:2] || o.opc !== e.w[31:24] || o.imm !== e.w[7:0]) begin
        n_fail++;
        $display("FAIL busy_capture: pc=%h addr=%h op=%h imm=%h, required pc=%h word %h",
                 o.pc, o.addr, o.opc, o.imm, e.pc, e.w);
      end
      n_chk++;
      if (o.valid !== 1'b1 || o.npc !== e.npc) begin
        n_fail++;
        $display("FAIL busy_exec: vld=%b next=%h, required 1/%h", o.valid, o.npc, e.npc);
      end
    end
  endtask

  task automatic test_branch();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h08, mk(OP_BEQ, 8'h03, 8'h00, 8'h00), BR_EQ, 1'b1, 0, 0, 32'h18));
    sb.push_back(mkexp(32'h18, mk(OP_J, 8'hFB, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'h08));
    sb.push_back(mkexp(32'h08, mk(OP_BEQ, 8'h03, 8'h00, 8'h00), BR_EQ, 1'b0, 0, 0, 32'h0C));
    sb.push_back(mkexp(32'h0C, mk(OP_J, 8'hFE, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'h08));
    sb.push_back(mkexp(32'h08, mk(OP_BNE, 8'h03, 8'h00, 8'h00), BR_NE, 1'b1, 0, 0, 32'h0C));
    sb.push_back(mkexp(32'h0C, mk(OP_J, 8'hFE, 8'h00, 8'h00), BR_J, 1'b1, 0, 0, 32'h08));
    sb.push_back(mkexp(32'h08, mk(OP_BNE, 8'h03, 8'h00, 8'h00), BR_NE, 1'b0, 0, 0, 32'h18));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.pc !== e.pc || o.opc !== e.w[31:24]) begin
        n_fail++;
        $display("FAIL branch_instr: pc=%h op=%h, required pc=%h op=%h", o.pc, o.opc, e.pc, e.w[31:24]);
      end
      n_chk++;
      if (o.npc !== e.npc) begin
        n_fail++;
        $display("FAIL branch_target br=%b z=%b: pc=%h, required %h", e.br, e.z, o.npc, e.npc);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h18, mk(OP_J, 8'h01, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'h20));
    sb.push_back(mkexp(32'h20, mk(OP_OR, 8'h02, 8'h03, 8'h04), BR_NONE, 1'b0, 0, 4, 32'h24));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.hold_ok !== 1'b1 || o.pc !== e.pc || o.opc !== e.w[31:24]) begin
        n_fail++;
        $display("FAIL stall_hold: held=%b pc=%h op=%h, required 1 pc=%h op=%h",
                 o.hold_ok, o.pc, o.opc, e.pc, e.w[31:24]);
      end
      n_chk++;
      if (o.npc !== e.npc || o.vld_after !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_release: pc=%h vld=%b, required %h/0", o.npc, o.vld_after, e.npc);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    exp_t e;
    sb.push_back(mkexp(32'h24, mk(OP_J, 8'hF5, 8'h00, 8'h00), BR_J, 1'b0, 0, 0, 32'hFFFFFFFC));
    sb.push_back(mkexp(32'hFFFFFFFC, mk(OP_ADD, 8'h00, 8'h00, 8'h11), BR_NONE, 1'b1, 0, 0, 32'h0));
    sb.push_back(mkexp(32'h00, mk(8'hEE, 8'h80, 8'h07, 8'h07), BR_NONE, 1'b1, 0, 0, 32'h04));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem[e.pc[9:2]] = e.w;
      exec_one(e.bw, e.st, e.br, e.z, o);
      n_chk++;
      if (o.pc !== e.pc || o.addr !== e.pc[9:2] || o.opc !== e.w[31:24]) begin
        n_fail++;
        $display("FAIL wrap_instr: pc=%h addr=%h op=%h, required pc=%h addr=%h op=%h",
                 o.pc, o.addr, o.opc, e.pc, e.pc[9:2], e.w[31:24]);
      end
      n_chk++;
      if (o.npc !== e.npc) begin
        n_fail++;
        $display("FAIL wrap_next_pc: pc=%h, required %h", o.npc, e.npc);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    mem[1] = mk(OP_AND, 8'h44, 8'h05, 8'h66);
    IMEM_BUSYWAIT = 1'b1;
    repeat (2) @(negedge CLK);
    n_chk++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 8'h01 || PC !== 32'h04) begin
      n_fail++;
      $display("FAIL rstmid_pre: rd=%b addr=%h pc=%h, required 1/01/00000004", IMEM_READ, IMEM_ADDRESS, PC);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    n_chk++;
    if (PC !== 32'h0 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: pc=%h rd=%b vld=%b, required 0/0/0", PC, IMEM_READ, INSTR_VALID);
    end
    n_chk++;
    if (OPCODE !== 8'h00 || IMMEDIATE !== 8'h00 || OFFSET !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_ir: op=%h imm=%h off=%h, required 0", OPCODE, IMMEDIATE, OFFSET);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDRESS !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_restart: rd=%b addr=%h, required 1/00", IMEM_READ, IMEM_ADDRESS);
    end
    sb.push_back(mkexp(32'h00, mk(OP_ROR, 8'h09, 8'h03, 8'h21), BR_NONE, 1'b0, 0, 0, 32'h04));
    e = sb.pop_front();
    mem[e.pc[9:2]] = e.w;
    exec_one(e.bw, e.st, e.br, e.z, o);
    n_chk++;
    if (o.pc !== e.pc || o.opc !== e.w[31:24] || o.npc !== e.npc) begin
      n_fail++;
      $display("FAIL rstmid_exec: pc=%h op=%h next=%h, required %h/%h/%h",
               o.pc, o.opc, o.npc, e.pc, e.w[31:24], e.npc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_seq();
    test_jump();
    test_busywait();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
